// File: rtl/dht11_poll_ctrl.sv
// DHT11 poll scheduler with timeout/retry, last-good capture and heat/cool hysteresis.
// Optional checksum validation is compiled in with `define DHT11_CHECKSUM_EN.
module dht11_poll_ctrl #(
  parameter int CLK_HZ     = 16000000,
  parameter int POLL_MS    = 2000,
  parameter int TIMEOUT_MS = 50,
  parameter int RETRY_MS   = 1100,
  parameter int MAX_RETRY  = 3,
  parameter int HYST       = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        start_o,
  input  logic        rd_done_i,
  input  logic [39:0] rd_data_i,
  input  logic [7:0]  setpoint_i,
  output logic [7:0]  temp_o,
  output logic [7:0]  hum_o,
  output logic        valid_o,
  output logic        sample_o,
  output logic        fault_o,
  output logic        heat_o,
  output logic        cool_o
);

  localparam int DIV    = (CLK_HZ / 1000 > 0) ? (CLK_HZ / 1000) : 1;
  localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LD_MAX = (POLL_MS > RETRY_MS) ? POLL_MS : RETRY_MS;
  localparam int WW     = (LD_MAX > 1) ? $clog2(LD_MAX + 1) : 1;
  localparam int TW     = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [WW-1:0] POLL_LD   = WW'(POLL_MS);
  localparam logic [WW-1:0] RETRY_LD  = WW'(RETRY_MS);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_MS - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [8:0]    HYST9     = 9'(HYST);

`ifdef DHT11_CHECKSUM_EN
  localparam logic CKSUM_EN = 1'b1;
`else
  localparam logic CKSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  // Frame is good when the low byte equals the 8-bit wrap-around sum of the upper four bytes.
  function automatic logic frame_ok(input logic [39:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return (s == f[7:0]);
  endfunction

  state_t          state_r, state_s;
  logic [PW-1:0]   presc_r;
  logic            tick_r;
  logic [WW-1:0]   wait_r;
  logic [TW-1:0]   to_r;
  logic            done_r;
  logic            cks_ok_r;
  logic [7:0]      temp_lat_r, hum_lat_r;
  logic [7:0]      temp_r, hum_r;
  logic            valid_r, sample_r, fault_r, start_r;
  logic [3:0]      retry_r;
  logic            heat_r, cool_r;
  logic            capture_s, good_s;
  logic [8:0]      temp9_s, sp9_s;

  assign capture_s = (state_r == ST_WAIT) & rd_done_i & ~done_r;
  assign good_s    = cks_ok_r | ~CKSUM_EN;
  assign temp9_s   = {1'b0, temp_r};
  assign sp9_s     = {1'b0, setpoint_i};

  // Free-running 1 ms prescaler; tick_r is a registered one-cycle strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      if (presc_r == PRESC_MAX) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
      tick_r <= (presc_r == PRESC_MAX);
    end
  end

  // Latch the first completed frame seen in WAIT; anything outside WAIT is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_r     <= 1'b0;
      cks_ok_r   <= 1'b0;
      temp_lat_r <= 8'd0;
      hum_lat_r  <= 8'd0;
    end else begin
      done_r <= capture_s;
      if (capture_s) begin
        cks_ok_r   <= frame_ok(rd_data_i);
        temp_lat_r <= rd_data_i[23:16];
        hum_lat_r  <= rd_data_i[39:32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a completed frame takes priority over a coincident timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tick_r && (wait_r == '0)) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ:  state_s = ST_WAIT;
      ST_WAIT: begin
        if (done_r) begin
          state_s = ST_CHECK;
        end else if (tick_r && (to_r == TO_LAST) && !rd_done_i) begin
          state_s = ST_FAIL;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (good_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FAIL;
        end
      end
      ST_FAIL: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Wait (poll/retry) and timeout counters, both advanced by the ms tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_r <= '0;
      to_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (tick_r && (wait_r != '0)) begin
            wait_r <= wait_r - WW'(1);
          end
        end
        ST_REQ:  to_r <= '0;
        ST_WAIT: begin
          if (tick_r && (to_r != TO_LAST)) begin
            to_r <= to_r + TW'(1);
          end
        end
        ST_CHECK: begin
          if (good_s) begin
            wait_r <= POLL_LD;
          end
        end
        ST_FAIL: wait_r <= RETRY_LD;
        default: wait_r <= '0;
      endcase
    end
  end

  // Request pulse, last-good capture, retry counting and fault flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_r  <= 1'b0;
      sample_r <= 1'b0;
      temp_r   <= 8'd0;
      hum_r    <= 8'd0;
      valid_r  <= 1'b0;
      fault_r  <= 1'b0;
      retry_r  <= 4'd0;
    end else begin
      start_r  <= (state_s == ST_REQ);
      sample_r <= (state_r == ST_CHECK) && good_s;
      if ((state_r == ST_CHECK) && good_s) begin
        temp_r  <= temp_lat_r;
        hum_r   <= hum_lat_r;
        valid_r <= 1'b1;
        fault_r <= 1'b0;
        retry_r <= 4'd0;
      end else if (state_r == ST_FAIL) begin
        if ((retry_r + 4'd1) >= RETRY_LIM) begin
          fault_r <= 1'b1;
          retry_r <= 4'd0;
        end else begin
          retry_r <= retry_r + 4'd1;
        end
      end
    end
  end

  // Hysteresis control in 9 bits so temp+HYST and setpoint+HYST cannot wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      heat_r <= 1'b0;
      cool_r <= 1'b0;
    end else if (!valid_r || fault_r) begin
      heat_r <= 1'b0;
      cool_r <= 1'b0;
    end else begin
      if (temp9_s >= sp9_s) begin
        heat_r <= 1'b0;
      end else if ((temp9_s + HYST9) < sp9_s) begin
        heat_r <= 1'b1;
      end
      if (temp9_s <= sp9_s) begin
        cool_r <= 1'b0;
      end else if (temp9_s > (sp9_s + HYST9)) begin
        cool_r <= 1'b1;
      end
    end
  end

  assign start_o  = start_r;
  assign temp_o   = temp_r;
  assign hum_o    = hum_r;
  assign valid_o  = valid_r;
  assign sample_o = sample_r;
  assign fault_o  = fault_r;
  assign heat_o   = heat_r;
  assign cool_o   = cool_r;

endmodule

// File: tb/tb_dht11_poll_ctrl.sv
// Randomised bench for dht11_poll_ctrl: acts as the reader and compares against a
// transaction-level model of capture, retry/fault and hysteresis behaviour.
module tb_dht11_poll_ctrl;

  localparam int CLK_HZ     = 1000;
  localparam int POLL_MS    = 10;
  localparam int TIMEOUT_MS = 5;
  localparam int RETRY_MS   = 3;
  localparam int MAX_RETRY  = 3;
  localparam int HYST       = 1;

`ifdef DHT11_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rd_done_i = 1'b0;
  logic [39:0] rd_data_i = 40'd0;
  logic [7:0]  setpoint_i = 8'd25;
  logic        start_o, valid_o, sample_o, fault_o, heat_o, cool_o;
  logic [7:0]  temp_o, hum_o;

  int total = 0;
  int bad   = 0;

  int m_temp, m_hum, m_fails;
  bit m_valid, m_fault, m_heat, m_cool;

  dht11_poll_ctrl #(
    .CLK_HZ(CLK_HZ), .POLL_MS(POLL_MS), .TIMEOUT_MS(TIMEOUT_MS),
    .RETRY_MS(RETRY_MS), .MAX_RETRY(MAX_RETRY), .HYST(HYST)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_o(start_o), .rd_done_i(rd_done_i),
    .rd_data_i(rd_data_i), .setpoint_i(setpoint_i), .temp_o(temp_o), .hum_o(hum_o),
    .valid_o(valid_o), .sample_o(sample_o), .fault_o(fault_o), .heat_o(heat_o),
    .cool_o(cool_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_temp = 0; m_hum = 0; m_fails = 0;
    m_valid = 0; m_fault = 0; m_heat = 0; m_cool = 0;
  endtask

  task automatic model_hyst();
    int t;
    int sp;
    t  = m_temp;
    sp = int'(setpoint_i);
    if (!m_valid || m_fault) begin
      m_heat = 0;
      m_cool = 0;
    end else begin
      if (t >= sp) m_heat = 0;
      else if (t + HYST < sp) m_heat = 1;
      if (t <= sp) m_cool = 0;
      else if (t > sp + HYST) m_cool = 1;
    end
  endtask

  task automatic make_frame(input int t, input int h, input bit good, input bit rnd_dec,
                            output logic [39:0] f);
    int hd, td, ck;
    hd = rnd_dec ? $urandom_range(9, 0) : 0;
    td = rnd_dec ? $urandom_range(9, 0) : 0;
    ck = (h + hd + t + td) % 256;
    if (!good) ck = (ck + 1) % 256;
    f = {8'(h), 8'(hd), 8'(t), 8'(td), 8'(ck)};
  endtask

  task automatic check_state();
    chk("temp", temp_o, m_temp);
    chk("hum", hum_o, m_hum);
    chk("valid", valid_o, m_valid);
    chk("fault", fault_o, m_fault);
    chk("heat", heat_o, m_heat);
    chk("cool", cool_o, m_cool);
  endtask

  task automatic wait_start(output int gap, output int smp);
    gap = 0;
    smp = 0;
    do begin
      @(negedge clk_i);
      gap++;
      if (sample_o === 1'b1) smp++;
    end while (start_o !== 1'b1 && gap < 80);
    chk("start_seen", start_o, 1);
  endtask

  // Precondition: start_o has just been observed. kind 0=good, 1=bad checksum, 2=no reply.
  task automatic txn(input int kind, input int t, input int h, input bit rnd_dec);
    int d, gap, smp, lo, hi;
    bit good;
    logic [39:0] f;
    if (kind == 2) begin
      wait_start(gap, smp);
      good = 0;
      lo = TIMEOUT_MS + RETRY_MS;
      hi = lo + 5;
    end else begin
      d = $urandom_range(3, 1);
      repeat (d) @(negedge clk_i);
      make_frame(t, h, kind == 0, rnd_dec, f);
      rd_data_i = f;
      rd_done_i = 1'b1;
      @(negedge clk_i);
      rd_done_i = 1'b0;
      rd_data_i = 40'({$urandom, $urandom});
      wait_start(gap, smp);
      gap++;
      good = (kind == 0) || !CK_EN;
      lo = good ? POLL_MS + 1 : RETRY_MS + 1;
      hi = good ? POLL_MS + 6 : RETRY_MS + 7;
    end
    if (good) begin
      m_temp = t; m_hum = h; m_valid = 1; m_fault = 0; m_fails = 0;
    end else begin
      m_fails++;
      if (m_fails >= MAX_RETRY) begin
        m_fault = 1;
        m_fails = 0;
      end
    end
    model_hyst();
    chk("samples", smp, good ? 1 : 0);
    chk("gap_min", (gap >= lo && gap <= hi) ? lo : gap, lo);
    check_state();
  endtask

  task automatic release_reset();
    int g, s;
    logic [39:0] f;
    make_frame(30, 60, 1'b1, 1'b0, f);
    rst_ni    = 1'b1;
    rd_data_i = f;
    rd_done_i = 1'b1;
    @(negedge clk_i);
    rd_done_i = 1'b0;
    chk("start_early", start_o, 0);
    wait_start(g, s);
    chk("first_req_gap", g + 1, 2);
    chk("first_samples", s, 0);
    check_state();
  endtask

  int exp_heat[5] = '{1, 1, 0, 0, 0};
  int exp_cool[5] = '{0, 0, 0, 1, 0};
  int hyst_t[5]   = '{23, 24, 25, 27, 25};

  initial begin
    int r, kind;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_state();
    chk("start_rst", start_o, 0);
    chk("sample_rst", sample_o, 0);
    release_reset();

    // Good read from the plan: {45,0,25,0,70}.
    txn(0, 25, 45, 1'b0);
    chk("good_temp", temp_o, 25);
    chk("good_hum", hum_o, 45);

    setpoint_i = 8'd25;
    model_hyst();
    for (int i = 0; i < 5; i++) begin
      txn(0, hyst_t[i], 50, 1'b0);
      chk("hyst_heat", heat_o, exp_heat[i]);
      chk("hyst_cool", cool_o, exp_cool[i]);
    end

    // Heater on, then three bad-checksum frames.
    txn(0, 23, 40, 1'b0);
    for (int i = 0; i < 3; i++) txn(1, 23, 41, 1'b0);
    chk("bad_fault", fault_o, CK_EN);
    chk("bad_heat", heat_o, CK_EN ? 0 : 1);
    txn(0, 26, 42, 1'b0);
    chk("bad_recover", fault_o, 0);

    for (int i = 0; i < 3; i++) txn(2, 0, 0, 1'b0);
    chk("to_fault", fault_o, 1);
    txn(0, 24, 43, 1'b0);

    // Reset while the controller waits for the reader.
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    model_reset();
    check_state();
    release_reset();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        setpoint_i = 8'($urandom_range(28, 22));
        model_hyst();
      end
      r = $urandom_range(7, 0);
      kind = (r < 4) ? 0 : ((r < 6) ? 1 : 2);
      txn(kind, $urandom_range(32, 18), $urandom_range(95, 20), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
